// File: rtl/ram_sp_burst_reader.sv
// Burst read initiator for a single-port RAM: takes (addr, len) commands,
// issues credit-limited read strobes and streams the returned words out
// through a small first-word-fall-through FIFO with valid/ready.
module ram_sp_burst_reader #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 14,
    parameter int RAM_DEPTH  = 4096,
    parameter int LEN_WIDTH  = 15,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_dout_valid,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]      FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]        CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_slow_depth
        $warning("FIFO_DEPTH below RD_LATENCY+1 limits throughput below one word per cycle");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                state, state_nxt;
    logic                  init_done;
    logic [LEN_WIDTH-1:0]  issue_rem, out_rem;
    logic [CNT_W-1:0]      outstanding, fifo_count;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic                  cmd_fire, issue_go, credit_ok;
    logic                  fifo_push, fifo_pop, last_pop;
    logic [CNT_W:0]        credit_used;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign cmd_ready = init_done && (state == S_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state != S_IDLE);
    assign ram_we    = 1'b0;

    assign m_valid   = (fifo_count != '0);
    assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last    = m_valid && (out_rem == LEN_WIDTH'(1));
    assign fifo_pop  = m_valid && m_ready;
    assign last_pop  = fifo_pop && m_last;
    // A return with nothing outstanding is stray: it is dropped, not buffered.
    assign fifo_push = ram_dout_valid && (outstanding != '0);

    // The strobe is registered, so the decision is taken a cycle ahead of the
    // RAM seeing it; a slot freed by this cycle's pop is counted as available.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok   = credit_used < (CREDIT_MAX + (CNT_W + 1)'(fifo_pop));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_nxt = state;
        issue_go  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_fire && cmd_len != '0) begin
                    issue_go  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_rem != '0 && credit_ok) issue_go = 1'b1;
                if (issue_rem == '0 || (issue_go && issue_rem == LEN_WIDTH'(1)))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_pop) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command capture, RAM strobe/address, burst counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ram_en      <= 1'b0;
            ram_addr    <= '0;
            issue_rem   <= '0;
            out_rem     <= '0;
            outstanding <= '0;
        end else begin
            init_done <= 1'b1;
            done      <= (cmd_fire && cmd_len == '0) || last_pop;
            ram_en    <= issue_go;
            if (ram_dout_valid && outstanding == '0) err <= 1'b1;
            if (issue_go) begin
                ram_addr  <= (state == S_IDLE) ? cmd_addr : next_addr(ram_addr);
                issue_rem <= ((state == S_IDLE) ? cmd_len : issue_rem) - LEN_WIDTH'(1);
            end
            if (cmd_fire)      out_rem <= cmd_len;
            else if (fifo_pop) out_rem <= out_rem - LEN_WIDTH'(1);
            case ({issue_go, fifo_push})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Return FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Return FIFO storage; contents are only observable through the count.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= ram_dout;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_count == FIFO_FULL));

endmodule

// File: tb/tb_ram_sp_burst_reader.sv
// Directed bench for ram_sp_burst_reader with a behavioural two-cycle RAM
// and a queue scoreboard of expected stream words.
module tb_ram_sp_burst_reader;
    localparam int DW = 36;
    localparam int AW = 14;
    localparam int LW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic          ram_dout_valid;
    logic          done, busy, err;

    ram_sp_burst_reader dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .ram_dout_valid(ram_dout_valid),
        .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data valid two cycles after the enable cycle.
    logic [DW-1:0] ram_mem [4096];
    logic          pv0 = 1'b0, pv1 = 1'b0;
    logic [DW-1:0] pd0 = '0, pd1 = '0;
    logic          inj_vld = 1'b0;
    logic [DW-1:0] inj_data = '0;
    always @(posedge clk) begin
        pv0 <= ram_en;
        pd0 <= ram_mem[ram_addr[11:0]];
        pv1 <= pv0;
        pd1 <= pd0;
    end
    assign ram_dout_valid = pv1 | inj_vld;
    assign ram_dout       = inj_vld ? inj_data : pd1;

    function automatic logic [DW-1:0] word_at(input int a);
        return DW'(a);
    endfunction

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } sb_t;
    sb_t exp_q[$];
    logic [AW-1:0] addr_log[$];

    int total = 0, bad = 0;
    int en_cnt = 0, pop_cnt = 0, we_bad = 0, max_inflight = 0;
    int first_en_cyc = -1, last_en_cyc = -1, first_mv_cyc = -1, last_cyc = -1;
    int hs_cyc = 0, done_cyc = 0;
    logic          stall_prev = 1'b0, stall_last = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops, hold checks, strobe bookkeeping.
    always @(negedge clk) begin
        if (rst_n) begin
            sb_t e;
            if (ram_we !== 1'b0) we_bad++;
            if (ram_en) begin
                en_cnt++;
                addr_log.push_back(ram_addr);
                if (first_en_cyc < 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
            end
            if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (stall_prev && m_valid) begin
                check("hold_data", m_data, stall_data);
                check("hold_last", m_last, stall_last);
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (m_valid && m_ready) begin
                pop_cnt++;
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_last", m_last, e.last);
                end
                if (m_last) last_cyc = cyc;
            end
            if (en_cnt - pop_cnt > max_inflight) max_inflight = en_cnt - pop_cnt;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int  n;
        bit  ok;
        sb_t e;
        for (int i = 0; i < int'(l); i++) begin
            e.data = word_at((int'(a) + i) % 4096);
            e.last = (i == int'(l) - 1);
            exp_q.push_back(e);
        end
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok     = 1'b1;
                hs_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("cmd_handshake", ok, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(posedge clk); #1;
            if (rnd) m_ready = ($urandom_range(0, 99) < 30);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
            n++;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic clear_marks();
        first_en_cyc = -1;
        last_en_cyc  = -1;
        first_mv_cyc = -1;
        last_cyc     = -1;
        addr_log.delete();
    endtask

    initial begin
        int en_before;
        for (int i = 0; i < 4096; i++) ram_mem[i] = word_at(i);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        #1;
        check("rel_cmd_ready_low", cmd_ready, 0);
        @(posedge clk); #1;
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_busy", busy, 0);

        // Streaming read at full rate.
        m_ready = 1'b1;
        clear_marks();
        en_before = en_cnt;
        send_cmd(14'h010, 15'd8);
        check("busy_in_burst", busy, 1);
        wait_done(100, 1'b0);
        check("stream_first_en", first_en_cyc, hs_cyc + 1);
        check("stream_first_valid", first_mv_cyc, hs_cyc + 4);
        check("stream_en_count", en_cnt - en_before, 8);
        check("stream_en_span", last_en_cyc - first_en_cyc, 7);
        check("stream_valid_span", last_cyc - first_mv_cyc, 7);
        check("stream_done_cycle", done_cyc, last_cyc + 1);
        check("stream_cmd_ready", cmd_ready, 1);
        check("stream_q_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        check("stream_done_pulse", done, 0);

        // Address wrap at the top of the RAM.
        clear_marks();
        send_cmd(14'd4094, 15'd4);
        wait_done(100, 1'b0);
        check("wrap_addr_count", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("wrap_addr0", addr_log[0], 4094);
            check("wrap_addr1", addr_log[1], 4095);
            check("wrap_addr2", addr_log[2], 0);
            check("wrap_addr3", addr_log[3], 1);
        end
        check("wrap_q_empty", exp_q.size(), 0);

        // Backpressure at 30% ready duty.
        en_cnt       = 0;
        pop_cnt      = 0;
        max_inflight = 0;
        send_cmd(14'h200, 15'd64);
        wait_done(3000, 1'b1);
        m_ready = 1'b1;
        check("bp_pops", pop_cnt, 64);
        check("bp_credit_max_le4", max_inflight <= 4, 1);
        check("bp_q_empty", exp_q.size(), 0);

        // Zero length, then a stray RAM return.
        en_before = en_cnt;
        send_cmd(14'h005, 15'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("zero_no_ram_en", en_cnt - en_before, 0);
        check("zero_done_once", done, 0);
        check("pre_inject_err", err, 0);
        inj_data = 36'h123456789;
        inj_vld  = 1'b1;
        @(posedge clk); #1;
        inj_vld = 1'b0;
        check("inject_err", err, 1);
        check("inject_dropped", m_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", err, 1);

        // Reset in the middle of a burst.
        pop_cnt = 0;
        send_cmd(14'h300, 15'd16);
        for (int n = 0; n < 100 && pop_cnt < 3; n++) begin
            @(posedge clk); #1;
        end
        check("mid_three_words", pop_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_ram_en", ram_en, 0);
        check("mid_rst_ram_addr", ram_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_err", err, 0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        en_cnt  = 0;
        pop_cnt = 0;
        @(posedge clk); #1;
        check("post_rst_err", err, 0);
        check("post_rst_ready", cmd_ready, 1);
        send_cmd(14'h100, 15'd2);
        wait_done(100, 1'b0);
        check("post_rst_pops", pop_cnt, 2);
        check("post_rst_q_empty", exp_q.size(), 0);
        check("post_rst_err_clean", err, 0);

        check("ram_we_never_high", we_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
